// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-meter datapath.
//   DIGITS    : number of BCD digits in a value (hundred-thousands .. units)
//   state_t   : converter control state
//   bcd_valid : 1 when a 4-bit digit is a legal BCD code (0..9)
package freq_pkg;

  localparam int DIGITS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// One step of decimal-to-binary accumulation: sum = acc*10 + digit.
//   acc   : running N-bit accumulator
//   digit : next BCD digit (assumed already validated)
//   sum   : full-width result, N+4 bits, so the caller can detect overflow
module mul10_add #(
  parameter int N = 20
) (
  input  logic [N-1:0] acc,
  input  logic [3:0]   digit,
  output logic [N+3:0] sum
);

  logic [N+3:0] acc_w;

  assign acc_w = {4'b0000, acc};

  // *10 built from two shifts: 8*acc + 2*acc.
  assign sum = (acc_w << 3) + (acc_w << 1) + {{N{1'b0}}, digit};

endmodule

// File: rtl/dec_a_bin.sv
// Sequential BCD-to-binary converter, one digit per clock.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : conversion request, honoured only when idle
//   cm, dm, um, cen, dec, un : BCD digits, hundred-thousands down to units
//   bin                   : converted value, held until the next completion
//   busy                  : high while a conversion is running
//   done                  : one-cycle pulse when bin/err/ovf are updated
//   err                   : last request contained a digit above 9
//   ovf                   : last result did not fit in N bits (bin saturated)
//
// Handshake: start is sampled only in IDLE. An accepted valid request keeps
// busy high for DIGITS cycles and ends with a single done pulse; an invalid
// request answers with done+err on the accepting edge and never raises busy.
// start while busy is dropped, not queued.
module dec_a_bin
  import freq_pkg::*;
#(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   cm,
  input  logic [3:0]   dm,
  input  logic [3:0]   um,
  input  logic [3:0]   cen,
  input  logic [3:0]   dec,
  input  logic [3:0]   un,
  output logic [N-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         ovf
);

  state_t              state;
  state_t              state_nxt;
  logic [4*DIGITS-1:0] digits_in;
  logic [4*DIGITS-1:0] digits_q;
  logic                all_valid;
  logic [N-1:0]        acc;
  logic [2:0]          cnt;
  logic                ovf_flag;
  logic                last;
  logic [N+3:0]        sum;
  logic                flag_step;
  logic [N-1:0]        acc_step;

  assign digits_in = {cm, dm, um, cen, dec, un};
  assign all_valid = bcd_valid(cm) && bcd_valid(dm) && bcd_valid(um) &&
                     bcd_valid(cen) && bcd_valid(dec) && bcd_valid(un);
  assign last      = (cnt == 3'(DIGITS - 1));

  // The latched digits shift left each step, so the digit to consume is
  // always in the top nibble; no index mux needed.
  mul10_add #(.N(N)) u_mul10_add (
    .acc   (acc),
    .digit (digits_q[4*DIGITS-1 -: 4]),
    .sum   (sum)
  );

  // Once any step overflows the accumulator is pinned at all ones; the
  // sticky flag keeps it there even if a later step would wrap back down.
  assign flag_step = ovf_flag | (|sum[N+3:N]);
  assign acc_step  = flag_step ? {N{1'b1}} : sum[N-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (start && all_valid) state_nxt = CONV;
    end else begin
      if (last) state_nxt = IDLE;
    end
  end

  // Output logic
  always_comb begin
    busy = (state == CONV);
  end

  // Datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      bin      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          digits_q <= digits_in;
          acc      <= '0;
          cnt      <= '0;
          ovf_flag <= 1'b0;
          if (!all_valid) begin
            bin  <= '0;
            err  <= 1'b1;
            ovf  <= 1'b0;
            done <= 1'b1;
          end
        end
      end else begin
        acc      <= acc_step;
        ovf_flag <= flag_step;
        cnt      <= cnt + 3'd1;
        digits_q <= digits_q << 4;
        if (last) begin
          // Results move only together with done.
          bin  <= acc_step;
          ovf  <= flag_step;
          err  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
